// File: rtl/waveform_sample_buffer.sv
// -----------------------------------------------------------------------------
// waveform_sample_buffer
//
// Circular sample store feeding the waveform display stage. Decimated signed
// samples from the acquisition/filter path are written into a DEPTH-entry
// ring. During display, one sample is returned per screen column (hcount),
// with the oldest stored sample at the left. The read base and the fill level
// are frozen once per frame (hcount==0 && vcount==0) so the trace does not
// tear while new samples arrive.
//
// Parameters:
//   DEPTH     ring entries (power of two, one entry per screen column)
//   ADDR_W    log2(DEPTH)
//   SAMPLE_W  signed sample width
//   DECIMATE  accepted input samples per stored sample (>= 1)
//
// Ports:
//   clock        display/system clock
//   reset        asynchronous, active-high
//   sample_in    signed sample from the filter stage
//   sample_valid one-cycle strobe qualifying sample_in
//   freeze       high = suppress writes and hold the decimation phase
//   hcount       current pixel column
//   vcount       current pixel row
//   signal_out   signed sample for column hcount_out (0 outside the fill)
//   hcount_out   hcount delayed 2 cycles
//   vcount_out   vcount delayed 2 cycles
//   frame_fill   stored-sample count latched at frame start (0..DEPTH)
//
// Optional feature (macro WAVEFORM_BUF_MINMAX_EN):
//   frame_min    minimum sample written during the previous frame (0 if none)
//   frame_max    maximum sample written during the previous frame (0 if none)
// -----------------------------------------------------------------------------
module waveform_sample_buffer #(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 9,
  parameter int DECIMATE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       freeze,
  input  logic        [10:0]         hcount,
  input  logic        [9:0]          vcount,
  output logic signed [SAMPLE_W-1:0] signal_out,
  output logic        [10:0]         hcount_out,
  output logic        [9:0]          vcount_out,
  output logic        [ADDR_W:0]     frame_fill
`ifdef WAVEFORM_BUF_MINMAX_EN
  ,
  output logic signed [SAMPLE_W-1:0] frame_min,
  output logic signed [SAMPLE_W-1:0] frame_max
`endif
);

  localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIMATE - 1);
  localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------------
  logic [DEC_W-1:0]    dec_cnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     fill;
  logic [ADDR_W-1:0]   base;

  logic                accept;
  logic                wr_en;
  logic                frame_start;

  // ---------------------------------------------------------------------------
  // Read side signals
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]   base_eff;
  logic [ADDR_W:0]     fill_eff;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid;
  logic [31:0]         h_ext;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] rd_data;
  logic                s1_valid;
  logic [10:0]         s1_hcount;
  logic [9:0]          s1_vcount;

  always_comb begin
    accept      = sample_valid && !freeze;
    wr_en       = accept && (dec_cnt == DEC_LAST);
    frame_start = (hcount == 11'd0) && (vcount == 10'd0);
  end

  // The frame-start cycle is also column 0 of the new frame, so the read path
  // uses the values being latched this cycle rather than last frame's copies.
  always_comb begin
    if (frame_start) begin
      base_eff = (fill == FILL_FULL) ? wr_ptr : '0;
      fill_eff = fill;
    end else begin
      base_eff = base;
      fill_eff = frame_fill;
    end
    rd_addr  = base_eff + hcount[ADDR_W-1:0];
    h_ext    = 32'(hcount);
    rd_valid = (h_ext < 32'(DEPTH)) && (h_ext < 32'(fill_eff));
  end

  // ---------------------------------------------------------------------------
  // Decimation, write pointer, fill level and per-frame latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      base       <= '0;
      frame_fill <= '0;
    end else begin
      if (accept) begin
        if (wr_en) begin
          dec_cnt <= '0;
          wr_ptr  <= wr_ptr + ADDR_W'(1);
          if (fill != FILL_FULL) begin
            fill <= fill + (ADDR_W+1)'(1);
          end
        end else begin
          dec_cnt <= dec_cnt + DEC_W'(1);
        end
      end
      if (frame_start) begin
        base       <= base_eff;
        frame_fill <= fill_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample RAM: one write port, one synchronous read-first read port. Left
  // without reset so it maps onto block RAM; the valid flag masks stale data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
    rd_data <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Two-stage read pipeline with matching raster delay
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      signal_out <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      s1_valid   <= rd_valid;
      s1_hcount  <= hcount;
      s1_vcount  <= vcount;
      signal_out <= s1_valid ? rd_data : '0;
      hcount_out <= s1_hcount;
      vcount_out <= s1_vcount;
    end
  end

`ifdef WAVEFORM_BUF_MINMAX_EN
  // ---------------------------------------------------------------------------
  // Per-frame min/max of written samples. A write in the frame-start cycle
  // belongs to the new frame: trackers reload first, then take that sample.
  // ---------------------------------------------------------------------------
  localparam logic signed [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic signed [SAMPLE_W-1:0] run_min;
  logic signed [SAMPLE_W-1:0] run_max;
  logic                       any_wr;
  logic signed [SAMPLE_W-1:0] min_base;
  logic signed [SAMPLE_W-1:0] max_base;
  logic signed [SAMPLE_W-1:0] min_nxt;
  logic signed [SAMPLE_W-1:0] max_nxt;
  logic                       any_nxt;

  always_comb begin
    min_base = frame_start ? MAX_POS : run_min;
    max_base = frame_start ? MIN_NEG : run_max;
    min_nxt  = min_base;
    max_nxt  = max_base;
    if (wr_en && (sample_in < min_base)) begin
      min_nxt = sample_in;
    end
    if (wr_en && (sample_in > max_base)) begin
      max_nxt = sample_in;
    end
    any_nxt  = wr_en || (!frame_start && any_wr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_min   <= MAX_POS;
      run_max   <= MIN_NEG;
      any_wr    <= 1'b0;
      frame_min <= '0;
      frame_max <= '0;
    end else begin
      run_min <= min_nxt;
      run_max <= max_nxt;
      any_wr  <= any_nxt;
      if (frame_start) begin
        frame_min <= any_wr ? run_min : '0;
        frame_max <= any_wr ? run_max : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_waveform_sample_buffer.sv
module tb_waveform_sample_buffer;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int SW     = 9;
  localparam int DEC    = 4;
  localparam int IDLE_H = 1500;
  localparam int IDLE_V = 5;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 freeze = 1'b0;
  logic        [10:0]   hcount = 11'(IDLE_H);
  logic        [9:0]    vcount = 10'(IDLE_V);
  logic signed [SW-1:0] signal_out;
  logic        [10:0]   hcount_out;
  logic        [9:0]    vcount_out;
  logic        [ADDR_W:0] frame_fill;
`ifdef WAVEFORM_BUF_MINMAX_EN
  logic signed [SW-1:0] frame_min;
  logic signed [SW-1:0] frame_max;
`endif

  waveform_sample_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SW),
    .DECIMATE (DEC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .freeze       (freeze),
    .hcount       (hcount),
    .vcount       (vcount),
    .signal_out   (signal_out),
    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),
    .frame_fill   (frame_fill)
`ifdef WAVEFORM_BUF_MINMAX_EN
    ,
    .frame_min    (frame_min),
    .frame_max    (frame_max)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ring as a plain array, indices kept as integers.
  int m_mem [DEPTH];
  int m_wr, m_dec, m_fill, m_base, m_ff;
  int m_rmin, m_rmax, m_any, m_fmin, m_fmax;
  int p1_s, p1_h, p1_v, p2_s, p2_h, p2_v;
  int seen [1100];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_wr = 0; m_dec = 0; m_fill = 0; m_base = 0; m_ff = 0;
    m_rmin = 255; m_rmax = -256; m_any = 0; m_fmin = 0; m_fmax = 0;
    p1_s = 0; p1_h = 0; p1_v = 0; p2_s = 0; p2_h = 0; p2_v = 0;
  endtask

  // One clock: advance the model with the inputs now applied, let the edge
  // happen, then compare every output on the falling edge.
  task automatic tick();
    int hc, vc, s, nb, nff, val;
    bit fs;
    hc = int'(hcount);
    vc = int'(vcount);
    s  = int'(sample_in);
    if (reset) begin
      mreset();
    end else begin
      fs  = (hc == 0) && (vc == 0);
      nb  = fs ? ((m_fill == DEPTH) ? m_wr : 0) : m_base;
      nff = fs ? m_fill : m_ff;
      val = (hc < DEPTH && hc < nff) ? m_mem[(nb + hc) % DEPTH] : 0;
      if (fs) begin
        m_fmin = m_any ? m_rmin : 0;
        m_fmax = m_any ? m_rmax : 0;
        m_rmin = 255; m_rmax = -256; m_any = 0;
      end
      if (sample_valid && !freeze) begin
        if (m_dec == DEC - 1) begin
          m_mem[m_wr] = s;
          m_wr   = (m_wr + 1) % DEPTH;
          m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
          m_dec  = 0;
          if (s < m_rmin) m_rmin = s;
          if (s > m_rmax) m_rmax = s;
          m_any = 1;
        end else begin
          m_dec++;
        end
      end
      m_base = nb;
      m_ff   = nff;
      p2_s = p1_s; p2_h = p1_h; p2_v = p1_v;
      p1_s = val;  p1_h = hc;   p1_v = vc;
    end
    @(posedge clock);
    @(negedge clock);
    chk("signal_out", int'(signal_out), p2_s);
    chk("hcount_out", int'(hcount_out), p2_h);
    chk("vcount_out", int'(vcount_out), p2_v);
    chk("frame_fill", int'(frame_fill), m_ff);
`ifdef WAVEFORM_BUF_MINMAX_EN
    chk("frame_min", int'(frame_min), m_fmin);
    chk("frame_max", int'(frame_max), m_fmax);
`endif
    if (!reset && vcount_out == 10'd0 && int'(hcount_out) < 1100)
      seen[int'(hcount_out)] = int'(signal_out);
  endtask

  task automatic idle();
    sample_valid = 1'b0;
    freeze = 1'b0;
    hcount = 11'(IDLE_H);
    vcount = 10'(IDLE_V);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe(input int v);
    sample_valid = 1'b1;
    sample_in = SW'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  // DEC-1 discarded strobes with random values, then the one that is kept.
  task automatic store(input int v);
    for (int i = 0; i < DEC - 1; i++) strobe(int'($urandom_range(0, 511)) - 256);
    strobe(v);
  endtask

  // Row 0 sweep starting at column 0 (frame start), then a 2-cycle flush.
  task automatic sweep(input int ncols, input bit rnd);
    for (int i = 0; i < 1100; i++) seen[i] = -999;
    for (int c = 0; c < ncols; c++) begin
      hcount = 11'(c);
      vcount = 10'd0;
      if (rnd) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = SW'($urandom);
        freeze       = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    hcount = 11'(IDLE_H);
    vcount = 10'(IDLE_V);
    if (rnd) begin
      sample_valid = 1'b0;
      freeze = 1'b0;
    end
    tick();
    tick();
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    mreset();

    // ---- reset, then reset asserted mid-stream ----
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = ~sample_valid;
      tick();
    end
    chk("reset_frame_fill", int'(frame_fill), 0);
    chk("reset_hcount_out", int'(hcount_out), 0);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 40; i++) strobe(int'($urandom_range(1, 200)));
    sweep(50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sample_valid = ~sample_valid;
      sample_in = SW'($urandom);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("async_reset_signal_out", int'(signal_out), 0);
    chk("async_reset_frame_fill", int'(frame_fill), 0);
    chk("async_reset_vcount_out", int'(vcount_out), 0);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      sample_valid = ~sample_valid;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    sweep(1026, 1'b0);
    chk("post_reset_frame_fill", int'(frame_fill), 0);
    cnt = 0;
    for (int c = 0; c < DEPTH; c++) if (seen[c] != 0) cnt++;
    chk("post_reset_nonzero_cols", cnt, 0);

    // ---- decimation: strobes 1..8 keep only 4 and 8 ----
    do_reset();
    idle();
    for (int v = 1; v <= 8; v++) strobe(v);
    sweep(1026, 1'b0);
    chk("dec_col0", seen[0], 4);
    chk("dec_col1", seen[1], 8);
    chk("dec_col2", seen[2], 0);
    chk("dec_frame_fill", int'(frame_fill), 2);

    // ---- latency: 0x055 at address 0, column 0 appears 2 cycles later ----
    do_reset();
    idle();
    store(85);
    tick();
    hcount = 11'd0;
    vcount = 10'd0;
    tick();
    chk("lat_hcount_out_c1", int'(hcount_out), IDLE_H);
    idle();
    tick();
    chk("lat_hcount_out_c2", int'(hcount_out), 0);
    chk("lat_signal_out_c2", int'(signal_out), 85);

    // ---- wrap: 1030 stored samples, value = index mod 256 ----
    do_reset();
    idle();
    for (int k = 0; k < 1030; k++) store(k % 256);
    sweep(1026, 1'b0);
    chk("wrap_col0", seen[0], 6);
    chk("wrap_col1017", seen[1017], 255);
    chk("wrap_col1023", seen[1023], 5);
    chk("wrap_col1024", seen[1024], 0);
    chk("wrap_frame_fill", int'(frame_fill), 1024);

    // ---- freeze: two frames strobing -63, ring unchanged ----
    freeze = 1'b1;
    sample_valid = 1'b1;
    sample_in = -9'sd63;
    sweep(1026, 1'b0);
    sweep(1026, 1'b0);
    cnt = 0;
    for (int c = 0; c < DEPTH; c++) if (seen[c] != (c + 6) % 256) cnt++;
    chk("freeze_bad_cols", cnt, 0);
    chk("freeze_col0", seen[0], 6);
    idle();
    store(77);
    sweep(1026, 1'b0);
    chk("unfreeze_col0", seen[0], 7);
    chk("unfreeze_col1023", seen[1023], 77);

`ifdef WAVEFORM_BUF_MINMAX_EN
    // ---- min/max over one frame, then an empty frame ----
    do_reset();
    idle();
    sweep(4, 1'b0);
    store(-100);
    store(37);
    store(255);
    sweep(4, 1'b0);
    chk("minmax_min", int'(frame_min), -100);
    chk("minmax_max", int'(frame_max), 255);
    sweep(4, 1'b0);
    chk("minmax_empty_min", int'(frame_min), 0);
    chk("minmax_empty_max", int'(frame_max), 0);
`endif

    // ---- randomized traffic across frames ----
    do_reset();
    idle();
    for (int f = 0; f < 8; f++) begin
      sweep(1030, 1'b1);
      for (int i = 0; i < 400; i++) begin
        hcount = 11'($urandom_range(0, 1100));
        vcount = 10'($urandom_range(0, 9));
        sample_valid = 1'($urandom_range(0, 1));
        sample_in = SW'($urandom);
        freeze = ($urandom_range(0, 9) == 0);
        tick();
      end
      idle();
    end
    for (int k = 0; k < 1100; k++) store(int'($urandom_range(0, 511)) - 256);
    sweep(1030, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
